// File: rtl/eth_rx_pkg.sv
// Shared definitions for the Ethernet RX byte packer.
//   rx_state_e      : packer FSM states (IDLE / PACK / DROP)
//   rx_desc_t       : per-frame descriptor layout {err, len} at the default length width
//   BYTES_PER_WORD  : bytes packed into one data FIFO word
//   DEFAULT_MAX_LEN : longest frame accepted before truncation
//   lane_pos()      : maps a byte lane index to its byte position inside the word
package eth_rx_pkg;

  localparam int BYTES_PER_WORD  = 4;
  localparam int DEFAULT_MAX_LEN = 1522;
  localparam int DEFAULT_LEN_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PACK = 2'd1,
    ST_DROP = 2'd2
  } rx_state_e;

  typedef struct packed {
    logic                     err;
    logic [DEFAULT_LEN_W-1:0] len;
  } rx_desc_t;

  // Lane 0 is the first byte of a word; MSB-first mode places it in the top byte.
  function automatic logic [1:0] lane_pos(input logic [1:0] idx, input bit msb_first);
    return msb_first ? (2'd3 - idx) : idx;
  endfunction

endpackage

// File: rtl/eth_rx_lane_shifter.sv
// Byte-to-word steering for the RX packer.
// Tracks the byte lane index, places each accepted byte into its lane and keeps
// unused lanes at zero so a flushed partial word comes out already padded.
// Ports:
//   clk, tb_rst   : clock, asynchronous active-high reset
//   i_accept      : byte on i_data is taken this cycle
//   i_first       : this byte starts a frame (lane index restarts at 0)
//   i_last        : this byte ends the frame (word is flushed, lane index clears)
//   i_data        : received byte
//   o_word        : word including the current byte, unused lanes zero
//   o_word_done   : current byte fills the last lane
module eth_rx_lane_shifter
  import eth_rx_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        tb_rst,
  input  logic        i_accept,
  input  logic        i_first,
  input  logic        i_last,
  input  logic [7:0]  i_data,
  output logic [31:0] o_word,
  output logic        o_word_done
);

  logic [1:0]  r_idx;
  logic [31:0] r_word;
  logic [1:0]  w_idx;
  logic [1:0]  w_pos;
  logic [31:0] w_base;

  // A frame start ignores whatever a dropped frame may have left behind.
  assign w_idx       = i_first ? 2'd0  : r_idx;
  assign w_base      = i_first ? 32'd0 : r_word;
  assign w_pos       = lane_pos(w_idx, MSB_FIRST);
  assign o_word      = w_base | ({24'd0, i_data} << {w_pos, 3'b000});
  assign o_word_done = i_accept && (w_idx == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      r_idx  <= 2'd0;
      r_word <= 32'd0;
    end else if (i_accept) begin
      if (o_word_done || i_last) begin
        r_idx  <= 2'd0;
        r_word <= 32'd0;
      end else begin
        r_idx  <= w_idx + 2'd1;
        r_word <= o_word;
      end
    end
  end

endmodule

// File: rtl/eth_rx_byte_packer.sv
// Packs the MAC RX byte stream into 32-bit words for the RX data FIFO and writes
// one {err, byte_count} descriptor per frame to the descriptor FIFO.
// Handshake: rx_valid is a pure valid strobe with no ready; a byte presented with
// rx_valid=1 is consumed (packed, counted or discarded) on that clock edge. rx_last
// only has meaning when rx_valid=1. wr_en / len_wr_en are one-cycle write strobes
// into FIFOs that advertise space through wr_full / almost_full.
// Ports:
//   clk, tb_rst            : clock, asynchronous active-high reset
//   rx_data/valid/last     : MAC RX byte interface
//   wr_full, almost_full   : data FIFO status
//   wr_data, wr_en         : data FIFO write port (registered)
//   len_data, len_wr_en    : descriptor FIFO write port {err, byte_count} (registered)
//   frame_cnt, drop_cnt    : good / errored frame counters, wrapping
//   dbg_state              : current FSM state
module eth_rx_byte_packer
  import eth_rx_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0,
  parameter int MAX_LEN   = DEFAULT_MAX_LEN,
  parameter int LEN_W     = DEFAULT_LEN_W
) (
  input  logic             clk,
  input  logic             tb_rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             rx_last,
  input  logic             wr_full,
  input  logic             almost_full,
  output logic [31:0]      wr_data,
  output logic             wr_en,
  output logic [LEN_W:0]   len_data,
  output logic             len_wr_en,
  output logic [LEN_W-1:0] frame_cnt,
  output logic [LEN_W-1:0] drop_cnt,
  output rx_state_e        dbg_state
);

  rx_state_e        r_state;
  logic [LEN_W-1:0] r_len;

  logic             w_first;
  logic             w_accept;
  logic             w_word_done;
  logic [31:0]      w_word;
  logic             w_need_write;
  logic             w_lost;
  logic             w_end;
  logic             w_end_err;
  logic             w_at_max;
  logic [LEN_W-1:0] w_len_base;
  logic [LEN_W-1:0] w_len_next;

  // almost_full is only consulted when a frame starts; once packing, the frame runs on.
  assign w_first      = (r_state == ST_IDLE);
  assign w_accept     = rx_valid && ((w_first && !almost_full) || (r_state == ST_PACK));
  assign w_need_write = w_word_done || rx_last;
  assign w_lost       = w_accept && w_need_write && wr_full;

  // Every frame ends on rx_last whatever the state; it is clean only if its byte was packed
  // and its word made it into the FIFO (DROP and an almost_full start never accept).
  assign w_end        = rx_valid && rx_last;
  assign w_end_err    = !w_accept || w_lost;

  assign w_len_base   = w_first ? '0 : r_len;
  assign w_len_next   = (&w_len_base) ? w_len_base : w_len_base + LEN_W'(1);
  assign w_at_max     = (w_len_next == LEN_W'(MAX_LEN));

  assign dbg_state    = r_state;

  eth_rx_lane_shifter #(
    .MSB_FIRST(MSB_FIRST)
  ) u_lane (
    .clk        (clk),
    .tb_rst     (tb_rst),
    .i_accept   (w_accept),
    .i_first    (w_first),
    .i_last     (rx_last),
    .i_data     (rx_data),
    .o_word     (w_word),
    .o_word_done(w_word_done)
  );

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      r_state   <= ST_IDLE;
      r_len     <= '0;
      wr_data   <= 32'd0;
      wr_en     <= 1'b0;
      len_data  <= '0;
      len_wr_en <= 1'b0;
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      wr_en     <= 1'b0;
      len_wr_en <= 1'b0;

      if (rx_valid) r_len <= w_len_next;

      if (w_accept && w_need_write && !wr_full) begin
        wr_en   <= 1'b1;
        wr_data <= w_word;
      end

      if (w_end) begin
        len_wr_en <= 1'b1;
        len_data  <= {w_end_err, w_len_next};
        if (w_end_err) drop_cnt  <= drop_cnt + LEN_W'(1);
        else           frame_cnt <= frame_cnt + LEN_W'(1);
      end

      case (r_state)
        ST_IDLE: begin
          if (rx_valid && !rx_last) begin
            if (!w_accept || w_lost || w_at_max) r_state <= ST_DROP;
            else                                 r_state <= ST_PACK;
          end
        end
        ST_PACK: begin
          if (rx_valid) begin
            if (rx_last)                r_state <= ST_IDLE;
            else if (w_lost || w_at_max) r_state <= ST_DROP;
          end
        end
        ST_DROP: begin
          if (w_end) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_rx_byte_packer.sv
// Bench for eth_rx_byte_packer: table of directed frames, hand-written multi-cycle
// sequences (mid-frame reset, back-to-back frames) and randomized frames, all
// scored against a frame-level reference model.
module tb_eth_rx_byte_packer;
  import eth_rx_pkg::*;

  localparam int LEN_W   = 16;
  localparam int MAX_LEN = 1522;
  localparam int NEVER   = 1 << 30;
  localparam int NV      = 10;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             tb_rst = 1'b1;
  logic [7:0]       rx_data = 8'd0;
  logic             rx_valid = 1'b0;
  logic             rx_last = 1'b0;
  logic             wr_full = 1'b0;
  logic             almost_full = 1'b0;
  logic [31:0]      wr_data;
  logic             wr_en;
  logic [LEN_W:0]   len_data;
  logic             len_wr_en;
  logic [LEN_W-1:0] frame_cnt;
  logic [LEN_W-1:0] drop_cnt;
  rx_state_e        dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  eth_rx_byte_packer #(
    .MSB_FIRST(1'b0),
    .MAX_LEN  (MAX_LEN),
    .LEN_W    (LEN_W)
  ) dut (
    .clk        (clk),
    .tb_rst     (tb_rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_last    (rx_last),
    .wr_full    (wr_full),
    .almost_full(almost_full),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .len_data   (len_data),
    .len_wr_en  (len_wr_en),
    .frame_cnt  (frame_cnt),
    .drop_cnt   (drop_cnt),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [31:0]    exp_word_q[$];
  logic [LEN_W:0] exp_desc_q[$];
  logic [31:0]    got_word_log[$];
  int             got_word_cyc[$];
  int             got_descs = 0;
  logic [LEN_W:0] last_desc = '0;
  int             last_desc_cyc = 0;
  int             exp_frame_cnt = 0;
  int             exp_drop_cnt = 0;
  int             n_checks = 0;
  int             n_fail = 0;
  logic [7:0]     frame_q[$];
  int             last_drive_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : mon
    logic [LEN_W:0] d;
    if (!tb_rst) begin
      if (wr_en) begin
        got_word_log.push_back(wr_data);
        got_word_cyc.push_back(cyc);
        if (exp_word_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL stray_word: got 0x%08h with no word expected", wr_data);
        end else begin
          check("word", wr_data, exp_word_q.pop_front());
        end
      end
      if (len_wr_en) begin
        got_descs++;
        last_desc     = len_data;
        last_desc_cyc = cyc;
        if (exp_desc_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL stray_desc: got 0x%0h with no descriptor expected", len_data);
        end else begin
          d = exp_desc_q.pop_front();
          check("desc", len_data, d);
          if (d[LEN_W]) exp_drop_cnt++;
          else          exp_frame_cnt++;
        end
        check("frame_cnt", frame_cnt, exp_frame_cnt[LEN_W-1:0]);
        check("drop_cnt", drop_cnt, exp_drop_cnt[LEN_W-1:0]);
      end
    end
  end

  // ---------------- reference model (frame level) ----------------
  // Words are groups of 4 bytes, first byte in the low lane. A word is due when its
  // 4th byte arrives, or at the last byte of a frame that fits in MAX_LEN; it is lost
  // if wr_full is high then. Bytes past MAX_LEN never reach the FIFO.
  task automatic model_frame(input int n, input bit af0, input int full_from);
    bit          err;
    int          acc;
    int          c;
    logic [31:0] w;
    if (af0) begin
      exp_desc_q.push_back({1'b1, LEN_W'(n)});
      return;
    end
    err = (n > MAX_LEN);
    acc = (n > MAX_LEN) ? MAX_LEN : n;
    for (int base = 0; base < acc; base += 4) begin
      if (base + 3 < acc)     c = base + 3;
      else if (n <= MAX_LEN) c = n - 1;
      else                   break;
      if (c >= full_from) begin
        err = 1'b1;
        break;
      end
      w = 32'd0;
      for (int j = 0; j < 4; j++)
        if (base + j < acc) w[8*j +: 8] = frame_q[base + j];
      exp_word_q.push_back(w);
    end
    exp_desc_q.push_back({err, LEN_W'(n)});
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_cycle(input bit v, input logic [7:0] d, input bit l, input bit af, input bit fl);
    rx_valid    = v;
    rx_data     = d;
    rx_last     = l;
    almost_full = af;
    wr_full     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic build_frame(input int n, input logic [7:0] first, input logic [7:0] stride);
    frame_q.delete();
    for (int i = 0; i < n; i++) frame_q.push_back(8'(first + i * stride));
  endtask

  task automatic build_random(input int n);
    frame_q.delete();
    for (int i = 0; i < n; i++) frame_q.push_back(8'($urandom));
  endtask

  // Gap cycles carry random junk (including rx_last) with rx_valid low.
  task automatic send_frame(input int n, input bit af0, input int full_from, input int max_gap);
    int g;
    model_frame(n, af0, full_from);
    for (int i = 0; i < n; i++) begin
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int k = 0; k < g; k++)
        drive_cycle(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      if (i == n - 1) last_drive_cyc = cyc;
      drive_cycle(1'b1, frame_q[i], (i == n - 1), (i == 0) ? af0 : 1'($urandom), (i >= full_from));
    end
    rx_valid    = 1'b0;
    rx_last     = 1'b0;
    almost_full = 1'b0;
    wr_full     = 1'b0;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    int          n;
    logic [7:0]  first;
    logic [7:0]  stride;
    bit          af0;
    int          full_from;
    bit          exp_err;
    int          exp_len;
    int          exp_words;
    bit          chk_w;
    logic [31:0] exp_w0;
    logic [31:0] exp_wlast;
  } vec_t;

  vec_t vecs[NV];

  initial begin
    int       w_before;
    int       d_before;
    int       n;
    int       ff;
    rx_desc_t dd;

    vecs[0] = '{8,    8'h01, 8'h01, 1'b0, NEVER, 1'b0, 8,    2,   1'b1, 32'h04030201, 32'h08070605};
    vecs[1] = '{5,    8'hAA, 8'h11, 1'b0, NEVER, 1'b0, 5,    2,   1'b1, 32'hDDCCBBAA, 32'h000000EE};
    vecs[2] = '{12,   8'h01, 8'h01, 1'b0, 5,     1'b1, 12,   1,   1'b1, 32'h04030201, 32'h04030201};
    vecs[3] = '{64,   8'h00, 8'h01, 1'b1, NEVER, 1'b1, 64,   0,   1'b0, 32'h0,        32'h0};
    vecs[4] = '{1600, 8'h00, 8'h01, 1'b0, NEVER, 1'b1, 1600, 380, 1'b1, 32'h03020100, 32'hEFEEEDEC};
    vecs[5] = '{1,    8'h5A, 8'h00, 1'b0, NEVER, 1'b0, 1,    1,   1'b1, 32'h0000005A, 32'h0000005A};
    vecs[6] = '{4,    8'h11, 8'h11, 1'b0, NEVER, 1'b0, 4,    1,   1'b1, 32'h44332211, 32'h44332211};
    vecs[7] = '{1522, 8'h00, 8'h01, 1'b0, NEVER, 1'b0, 1522, 381, 1'b1, 32'h03020100, 32'h0000F1F0};
    vecs[8] = '{1523, 8'h00, 8'h01, 1'b0, NEVER, 1'b1, 1523, 380, 1'b1, 32'h03020100, 32'hEFEEEDEC};
    vecs[9] = '{3,    8'h30, 8'h01, 1'b0, 2,     1'b1, 3,    0,   1'b0, 32'h0,        32'h0};

    // reset values, sampled while tb_rst is held
    #100;
    check("rst_wr_en", wr_en, 0);
    check("rst_len_wr_en", len_wr_en, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_len_data", len_data, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_state", dbg_state, ST_IDLE);
    #100;
    tb_rst = 1'b0;
    @(posedge clk);
    #1;
    idle(2);

    // table-driven frames
    for (int v = 0; v < NV; v++) begin
      w_before = got_word_log.size();
      d_before = got_descs;
      build_frame(vecs[v].n, vecs[v].first, vecs[v].stride);
      send_frame(vecs[v].n, vecs[v].af0, vecs[v].full_from, (vecs[v].n < 100) ? 2 : 0);
      idle(2);
      dd = last_desc;
      check($sformatf("v%0d_ndesc", v), got_descs - d_before, 1);
      check($sformatf("v%0d_err", v), dd.err, vecs[v].exp_err);
      check($sformatf("v%0d_len", v), dd.len, LEN_W'(vecs[v].exp_len));
      check($sformatf("v%0d_nwords", v), got_word_log.size() - w_before, vecs[v].exp_words);
      check($sformatf("v%0d_desc_latency", v), last_desc_cyc, last_drive_cyc + 1);
      if (vecs[v].chk_w && got_word_log.size() > w_before) begin
        check($sformatf("v%0d_w0", v), got_word_log[w_before], vecs[v].exp_w0);
        check($sformatf("v%0d_wlast", v), got_word_log[got_word_log.size() - 1], vecs[v].exp_wlast);
      end
      if (!vecs[v].exp_err && got_word_log.size() > w_before)
        check($sformatf("v%0d_wr_len_coincide", v), got_word_cyc[got_word_cyc.size() - 1], last_desc_cyc);
    end

    // mid-frame reset: three bytes, reset, then a clean 4-byte frame
    build_frame(3, 8'hA1, 8'h01);
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, frame_q[i], 1'b0, 1'b0, 1'b0);
    rx_valid = 1'b0;
    tb_rst   = 1'b1;
    exp_frame_cnt = 0;
    exp_drop_cnt  = 0;
    idle(2);
    check("midrst_wr_en", wr_en, 0);
    check("midrst_len_wr_en", len_wr_en, 0);
    check("midrst_frame_cnt", frame_cnt, 0);
    check("midrst_drop_cnt", drop_cnt, 0);
    check("midrst_state", dbg_state, ST_IDLE);
    tb_rst = 1'b0;
    idle(2);
    w_before = got_word_log.size();
    d_before = got_descs;
    build_frame(4, 8'h11, 8'h11);
    send_frame(4, 1'b0, NEVER, 0);
    idle(2);
    check("postrst_ndesc", got_descs - d_before, 1);
    check("postrst_nwords", got_word_log.size() - w_before, 1);
    if (got_word_log.size() > w_before) check("postrst_word", got_word_log[w_before], 32'h44332211);
    check("postrst_desc", last_desc, {1'b0, 16'd4});
    check("postrst_frame_cnt", frame_cnt, 1);

    // back-to-back frames, no idle cycle between them
    w_before = got_word_log.size();
    d_before = got_descs;
    build_frame(3, 8'hB1, 8'h01);
    send_frame(3, 1'b0, NEVER, 0);
    build_frame(2, 8'hC1, 8'h01);
    send_frame(2, 1'b0, NEVER, 0);
    idle(2);
    check("b2b_ndesc", got_descs - d_before, 2);
    check("b2b_nwords", got_word_log.size() - w_before, 2);
    if (got_word_log.size() >= w_before + 2) begin
      check("b2b_word_a", got_word_log[w_before], 32'h00B3B2B1);
      check("b2b_word_b", got_word_log[w_before + 1], 32'h0000C2C1);
    end

    // randomized frames
    for (int f = 0; f < 60; f++) begin
      n  = ($urandom_range(11, 0) == 0) ? int'($urandom_range(1530, 1515)) : int'($urandom_range(40, 1));
      ff = ($urandom_range(4, 0) == 0) ? int'($urandom_range(n + 1, 0)) : NEVER;
      build_random(n);
      send_frame(n, ($urandom_range(5, 0) == 0), ff, int'($urandom_range(3, 0)));
    end
    idle(4);

    check("words_left", exp_word_q.size(), 0);
    check("descs_left", exp_desc_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
